// File: rtl/tmac_pkg.sv
`default_nettype none
// ============================================================================
// Module : tmac_pkg
// Brief  : Shared state encoding and default sizing for the tMAC sequencer.
// Rev    : 1.0
// ============================================================================
package tmac_pkg;

    localparam int c_N_TERMS = 16;
    localparam int c_DW      = 8;
    localparam int c_ACCW    = 12;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_ARM   = 3'd3,
        ST_RUN   = 3'd4,
        ST_DONE  = 3'd5
    } tmac_state_e;

endpackage : tmac_pkg
`default_nettype wire

// File: rtl/tmac_acc.sv
`default_nettype none
// ============================================================================
// Module : tmac_acc
// Brief  : Unsigned bit-count accumulator (clear, enable, 1-bit increment).
// Rev    : 1.0
// ============================================================================
module tmac_acc
    import tmac_pkg::*;
#(
    parameter int ACCW = c_ACCW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_clr,
    input  logic            i_en,
    input  logic            i_inc,
    output logic [ACCW-1:0] o_acc
);

    logic [ACCW-1:0] r_acc;

    // Width is sized so the count can never wrap; no saturation needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en && i_inc) begin
            r_acc <= r_acc + ACCW'(1);
        end
    end

    assign o_acc = r_acc;

endmodule : tmac_acc
`default_nettype wire

// File: rtl/tmac_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tmac_seq_ctrl
// Brief  : Sequences N_TERMS operand pairs through a tMUL, accumulating oC.
// Rev    : 1.0
// ============================================================================
module tmac_seq_ctrl
    import tmac_pkg::*;
#(
    parameter int N_TERMS = c_N_TERMS,
    parameter int DW      = c_DW,
    parameter int ACCW    = c_ACCW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    input  logic            op_valid,
    input  logic [DW-1:0]   op_a,
    input  logic [DW-1:0]   op_b,
    output logic            op_ready,
    output logic [DW-1:0]   mul_a,
    output logic [DW-1:0]   mul_b,
    output logic            mul_loadA,
    output logic            mul_loadB,
    input  logic            mul_oC,
    input  logic            mul_stop,
    output logic            rng_clr,
    output logic            rng_en,
    output logic            res_valid,
    output logic [ACCW-1:0] res_data,
    input  logic            res_ready
);

    localparam int c_CNTW = $clog2(N_TERMS + 1);

    tmac_state_e       r_state;
    tmac_state_e       w_state_nxt;
    logic [c_CNTW-1:0] r_term_cnt;
    logic [DW-1:0]     r_mul_a;
    logic [DW-1:0]     r_mul_b;
    logic              r_load;
    logic              r_res_valid;

    logic              w_clear;
    logic              w_accept;
    logic              w_term_done;
    logic              w_last;
    logic              w_acc_en;

    assign w_clear     = (r_state == ST_IDLE) && start;
    assign w_accept    = (r_state == ST_FETCH) && op_valid;
    assign w_term_done = (r_state == ST_RUN) && mul_stop;
    assign w_last      = (r_term_cnt == c_CNTW'(N_TERMS - 1));
    assign w_acc_en    = (r_state == ST_RUN) && !mul_stop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ARM exists because the multiplier reports stop for one cycle after load.
    always_comb begin
        w_state_nxt = r_state;
        op_ready    = 1'b0;
        rng_en      = 1'b0;
        busy        = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                op_ready = 1'b1;
                if (op_valid) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: w_state_nxt = ST_ARM;
            ST_ARM:  w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (mul_stop) begin
                    w_state_nxt = w_last ? ST_DONE : ST_FETCH;
                end else begin
                    rng_en = 1'b1;
                end
            end
            ST_DONE: begin
                if (res_ready) w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                busy        = 1'b0;
            end
        endcase
    end

    // Strobes are registered from the transition into LOAD/DONE so they
    // line up exactly with the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_term_cnt  <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_load      <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            r_load      <= w_accept;
            r_res_valid <= (w_state_nxt == ST_DONE);
            if (w_accept) begin
                r_mul_a <= op_a;
                r_mul_b <= op_b;
            end
            if (w_clear) begin
                r_term_cnt <= '0;
            end else if (w_term_done) begin
                r_term_cnt <= r_term_cnt + c_CNTW'(1);
            end
        end
    end

    tmac_acc #(
        .ACCW (ACCW)
    ) u_acc (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_clear),
        .i_en  (w_acc_en),
        .i_inc (mul_oC),
        .o_acc (res_data)
    );

    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign mul_loadA = r_load;
    assign mul_loadB = r_load;
    assign rng_clr   = r_load;
    assign res_valid = r_res_valid;

endmodule : tmac_seq_ctrl
`default_nettype wire

// File: tb/tb_tmac_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_tmac_seq_ctrl
// Brief  : Self-checking bench for tmac_seq_ctrl with a tMUL + Sobol model.
// Rev    : 1.0
// ============================================================================
module tb_tmac_seq_ctrl;

    localparam int DW   = 8;
    localparam int ACCW = 12;

    logic            clk = 1'b0;
    logic            rst;
    logic            start = 1'b0;
    logic            busy;
    logic            op_valid = 1'b0;
    logic [DW-1:0]   op_a = '0;
    logic [DW-1:0]   op_b = '0;
    logic            op_ready;
    logic [DW-1:0]   mul_a;
    logic [DW-1:0]   mul_b;
    logic            mul_loadA;
    logic            mul_loadB;
    logic            mul_oC;
    logic            mul_stop;
    logic            rng_clr;
    logic            rng_en;
    logic            res_valid;
    logic [ACCW-1:0] res_data;
    logic            res_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int mode   = 1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tmac_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .op_valid  (op_valid),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_ready  (op_ready),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_loadA (mul_loadA),
        .mul_loadB (mul_loadB),
        .mul_oC    (mul_oC),
        .mul_stop  (mul_stop),
        .rng_clr   (rng_clr),
        .rng_en    (rng_en),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready)
    );

    // Multiplier model: down-counter loaded from mul_a, stepped by rng_en;
    // stop reads 1 right after a load and whenever the counter is empty.
    logic [7:0] m_cnt;
    logic [7:0] m_idx;
    logic       m_fresh;

    function automatic logic [7:0] bitrev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt   <= '0;
            m_idx   <= '0;
            m_fresh <= 1'b0;
        end else begin
            m_fresh <= mul_loadA;
            if (mul_loadA)                 m_cnt <= mul_a;
            else if (rng_en && m_cnt != 0) m_cnt <= m_cnt - 8'd1;
            if (rng_clr)     m_idx <= '0;
            else if (rng_en) m_idx <= m_idx + 8'd1;
        end
    end

    always_comb begin
        mul_stop = m_fresh || (m_cnt == 8'd0);
        case (mode)
            0:       mul_oC = 1'b0;
            1:       mul_oC = 1'b1;
            default: mul_oC = (bitrev8(m_idx) < mul_b);
        endcase
    end

    // Load-strobe monitor: records LOAD cycles and checks pulse shape.
    int   load_t[$];
    logic prev_load = 1'b0;
    always @(negedge clk) begin
        if (mul_loadA) begin
            load_t.push_back(cyc);
            checks++;
            if (prev_load || !mul_loadB || !rng_clr) begin
                errors++;
                $display("FAIL load_strobe actual=prev%0b/B%0b/clr%0b required=0/1/1",
                         prev_load, mul_loadB, rng_clr);
            end
        end
        prev_load <= mul_loadA;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_op_ready"},  op_ready,  0);
        chk({tag, "_loadA"},     mul_loadA, 0);
        chk({tag, "_loadB"},     mul_loadB, 0);
        chk({tag, "_rng_en"},    rng_en,    0);
        chk({tag, "_rng_clr"},   rng_clr,   0);
        chk({tag, "_res_valid"}, res_valid, 0);
    endtask

    task automatic feed_term(input logic [7:0] a, input logic [7:0] b,
                             input bit stall, output bit ok);
        int n = 0;
        while (!op_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("op_ready_wait", op_ready, 1);
        if (!op_ready) begin
            ok = 0;
            return;
        end
        if (stall) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                chk("stall_op_ready", op_ready, 1);
                chk("stall_loadA",    mul_loadA, 0);
            end
        end
        op_a     = a;
        op_b     = b;
        op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        ok = 1;
    endtask

    task automatic run_mac(input int md, input logic [7:0] a0, input int astep,
                           input logic [7:0] b, input int stall_term,
                           output logic [ACCW-1:0] res, output bit ok);
        int n = 0;
        mode = md;
        load_t.delete();
        res = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 16; t++) begin
            feed_term(a0 + 8'(astep * t), b, (t == stall_term), ok);
            if (!ok) return;
        end
        while (!res_valid && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("res_valid_wait", res_valid, 1);
        ok  = res_valid;
        res = res_data;
    endtask

    task automatic consume();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("consume_res_valid", res_valid, 0);
        chk("consume_busy",      busy,      0);
    endtask

    typedef struct {
        int         md;
        logic [7:0] a0;
        int         astep;
        logic [7:0] b;
        int         exp;
        int         tol;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [ACCW-1:0] res;
        logic [ACCW-1:0] held;
        bit              ok;

        vecs[0] = '{1, 8'd255, 0, 8'd0,   4080, 0};
        vecs[1] = '{1, 8'd0,   1, 8'd0,   120,  0};
        vecs[2] = '{2, 8'd255, 0, 8'd128, 2048, 16};
        vecs[3] = '{1, 8'd0,   0, 8'd0,   0,    0};
        vecs[4] = '{0, 8'd255, 0, 8'd0,   0,    0};
        vecs[5] = '{1, 8'd3,   0, 8'd0,   48,   0};
        vecs[6] = '{2, 8'd255, 0, 8'd255, 4080, 16};
        vecs[7] = '{2, 8'd255, 0, 8'd0,   0,    0};

        rst = 1'b0;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        chk("reset_res_data", res_data, 0);
        chk("reset_mul_a",    mul_a,    0);
        chk("reset_mul_b",    mul_b,    0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_reset_busy", busy, 0);

        for (int v = 0; v < 8; v++) begin
            run_mac(vecs[v].md, vecs[v].a0, vecs[v].astep, vecs[v].b, -1, res, ok);
            if (ok) begin
                chk_rng($sformatf("vec%0d_res_data", v), int'(res),
                        vecs[v].exp - vecs[v].tol, vecs[v].exp + vecs[v].tol);
                chk($sformatf("vec%0d_busy_done", v), busy, 1);
                if (load_t.size() >= 2)
                    chk($sformatf("vec%0d_term_latency", v), load_t[1] - load_t[0],
                        int'(vecs[v].a0) + 4);
                chk($sformatf("vec%0d_load_count", v), load_t.size(), 16);
                consume();
            end
        end

        // Operand stall mid-MAC does not change the sum.
        run_mac(1, 8'd3, 0, 8'd0, 5, res, ok);
        if (ok) begin
            chk("stall_res_data", res, 48);
            consume();
        end

        // Result held in DONE; a start pulse there is neither taken nor queued.
        run_mac(1, 8'd5, 0, 8'd0, -1, res, ok);
        if (ok) begin
            held = res_data;
            chk("hold_initial", held, 80);
            for (int i = 0; i < 5; i++) begin
                if (i == 2) start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                chk("hold_res_valid", res_valid, 1);
                chk("hold_res_data",  res_data,  held);
            end
            consume();
            repeat (3) @(negedge clk);
            chk("no_queued_start_busy", busy, 0);
            chk("no_queued_start_ready", op_ready, 0);
        end

        // Reset asserted during RUN of term 7, then a clean full MAC.
        mode  = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 8; t++) begin
            feed_term(8'd255, 8'd0, 1'b0, ok);
            if (!ok) break;
        end
        repeat (20) @(negedge clk);
        chk("mid_run_rng_en", rng_en, 1);
        rst = 1'b1;
        @(negedge clk);
        chk_idle_outputs("midrst");
        chk("midrst_res_data", res_data, 0);
        chk("midrst_mul_a",    mul_a,    0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("after_midrst_busy",      busy,      0);
        chk("after_midrst_res_valid", res_valid, 0);
        run_mac(1, 8'd255, 0, 8'd0, -1, res, ok);
        if (ok) begin
            chk("after_midrst_res_data", res, 4080);
            consume();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_tmac_seq_ctrl
`default_nettype wire
